// File: rtl/uart_tx_serializer_if.sv
// Read-side handshake between the synchronous TX FIFO and the UART serializer.
// The serializer is the master: it issues pops and consumes empty/data.
interface uart_tx_serializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_pop;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data_out;

   modport master (output fifo_pop, input fifo_empty, input fifo_data_out);
   modport slave  (input fifo_pop, output fifo_empty, output fifo_data_out);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO byte per frame and shifts it out LSB-first.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tx_enable,
   uart_tx_serializer_if.master fifo,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int DIV_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  bit_end;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   // State, timing counters and the line itself are all flops; tx comes from its
   // own register so the serial line never glitches on state transitions.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state and datapath; cnt_q counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (div_q == DIV_LAST);

      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            cnt_d = '0;
            if (tx_enable && !fifo.fifo_empty) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d  = fifo.fifo_data_out;
            div_d    = '0;
            cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = (^fifo.fifo_data_out) ^ (PARITY_ODD != 0);
`endif
            state_d  = ST_START;
         end
         ST_START: begin
            if (bit_end) begin
               div_d   = '0;
               state_d = ST_DATA;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               div_d   = '0;
               shift_d = shift_q >> 1;
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               div_d   = '0;
               state_d = ST_STOP;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               div_d = '0;
               if (cnt_q == STOP_LAST) begin
                  cnt_d   = '0;
                  state_d = (tx_enable && !fifo.fifo_empty) ? ST_FETCH : ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level is derived from where the FSM will be next cycle.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = parity_q;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   assign fifo.fifo_pop = (state_q == ST_FETCH);
   assign tx_busy       = (state_q != ST_IDLE);
   assign tx_done       = (state_q == ST_STOP) && bit_end && (cnt_q == STOP_LAST);
   assign tx            = tx_q;

endmodule
